// File: rtl/mp64_mem_pkg.sv
// Shared definitions for the mp64 memory subsystem: SRAM read latency and
// response-tag sizing used by the dual-port SRAM arbiter.
package mp64_mem_pkg;

   localparam int unsigned NREQ_MAX = 32'd8;

   function automatic int unsigned rd_lat(input int unsigned out_reg);
      return 32'd1 + out_reg;
   endfunction

   function automatic int unsigned tag_w(input int unsigned n);
      return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
   endfunction

endpackage

// File: rtl/mp64_rr_pick.sv
// Cyclic first-set finder: returns the set bit of req closest at or after ptr,
// walking upward and wrapping past index N-1.
module mp64_rr_pick
   import mp64_mem_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic             found,
   output logic [PTR_W-1:0] idx
);

   // Choose the requester with the smallest cyclic distance from ptr
   always_comb begin
      int unsigned best_s;
      int unsigned dist_s;
      logic        take_s;
      best_s = N;
      idx    = {PTR_W{1'b0}};
      for (int unsigned i = 0; i < N; i++) begin
         dist_s = (i >= 32'(ptr)) ? (i - 32'(ptr)) : (i + N - 32'(ptr));
         take_s = req[i] && (dist_s < best_s);
         best_s = take_s ? dist_s : best_s;
         idx    = take_s ? PTR_W'(i) : idx;
      end
      found = (best_s < N);
   end

endmodule

// File: rtl/mp64_sram_dp_arb.sv
// Round-robin arbiter mapping up to two requests per cycle onto the two ports
// of a dual-port SRAM, returning read data to the owning requester.
module mp64_sram_dp_arb
   import mp64_mem_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned ADDR_W  = 14,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned OUT_REG = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [NREQ*DATA_W-1:0] rsp_rdata,
   output logic                   ce_a,
   output logic                   we_a,
   output logic [ADDR_W-1:0]      addr_a,
   output logic [DATA_W-1:0]      wdata_a,
   input  logic [DATA_W-1:0]      rdata_a,
   output logic                   ce_b,
   output logic                   we_b,
   output logic [ADDR_W-1:0]      addr_b,
   output logic [DATA_W-1:0]      wdata_b,
   input  logic [DATA_W-1:0]      rdata_b
);

   localparam int unsigned LAT   = rd_lat(OUT_REG);
   localparam int unsigned TAG_W = tag_w(NREQ);

   logic [TAG_W-1:0]  rr_ptr_r;
   logic [TAG_W-1:0]  rr_ptr_nxt_s;
   logic [TAG_W-1:0]  last_idx_s;
   logic [NREQ-1:0]   elig_s;
   logic [NREQ-1:0]   b_cand_s;
   logic [NREQ-1:0]   onehot_a_s;
   logic [NREQ-1:0]   onehot_b_s;
   logic              a_found_s;
   logic              b_found_s;
   logic [TAG_W-1:0]  a_idx_s;
   logic [TAG_W-1:0]  b_idx_s;
   logic              a_we_s;
   logic              b_we_s;
   logic [ADDR_W-1:0] a_addr_s;
   logic [ADDR_W-1:0] b_addr_s;
   logic [DATA_W-1:0] a_wdata_s;
   logic [DATA_W-1:0] b_wdata_s;
   logic [LAT-1:0]    pa_vld_r;
   logic [LAT-1:0]    pb_vld_r;
   logic [TAG_W-1:0]  pa_id_r [LAT];
   logic [TAG_W-1:0]  pb_id_r [LAT];
   logic [NREQ-1:0]   hit_a_s;
   logic [NREQ-1:0]   hit_b_s;
   logic [DATA_W-1:0] hold_r [NREQ];

   assign elig_s = rst_n ? req_valid : {NREQ{1'b0}};

   mp64_rr_pick #(.N(NREQ), .PTR_W(TAG_W)) u_pick_a (
      .req(elig_s), .ptr(rr_ptr_r), .found(a_found_s), .idx(a_idx_s)
   );

   // Route the port A winner's command fields
   always_comb begin
      onehot_a_s = {NREQ{1'b0}};
      a_we_s     = 1'b0;
      a_addr_s   = {ADDR_W{1'b0}};
      a_wdata_s  = {DATA_W{1'b0}};
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (a_found_s && (32'(a_idx_s) == i)) begin
            onehot_a_s[i] = 1'b1;
            a_we_s        = req_we[i];
            a_addr_s      = req_addr[i*ADDR_W +: ADDR_W];
            a_wdata_s     = req_wdata[i*DATA_W +: DATA_W];
         end else begin
            onehot_a_s[i] = 1'b0;
         end
      end
   end

   // Port B may not touch A's word if either side writes it
   always_comb begin
      b_cand_s = {NREQ{1'b0}};
      for (int unsigned i = 0; i < NREQ; i++) begin
         b_cand_s[i] = elig_s[i] & ~onehot_a_s[i] &
                       ~((req_addr[i*ADDR_W +: ADDR_W] == a_addr_s) & (req_we[i] | a_we_s));
      end
   end

   mp64_rr_pick #(.N(NREQ), .PTR_W(TAG_W)) u_pick_b (
      .req(b_cand_s), .ptr(rr_ptr_r), .found(b_found_s), .idx(b_idx_s)
   );

   // Route the port B winner's command fields
   always_comb begin
      onehot_b_s = {NREQ{1'b0}};
      b_we_s     = 1'b0;
      b_addr_s   = {ADDR_W{1'b0}};
      b_wdata_s  = {DATA_W{1'b0}};
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (b_found_s && (32'(b_idx_s) == i)) begin
            onehot_b_s[i] = 1'b1;
            b_we_s        = req_we[i];
            b_addr_s      = req_addr[i*ADDR_W +: ADDR_W];
            b_wdata_s     = req_wdata[i*DATA_W +: DATA_W];
         end else begin
            onehot_b_s[i] = 1'b0;
         end
      end
   end

   assign req_ready = onehot_a_s | onehot_b_s;
   assign ce_a      = a_found_s;
   assign we_a      = a_we_s;
   assign addr_a    = a_addr_s;
   assign wdata_a   = a_wdata_s;
   assign ce_b      = b_found_s;
   assign we_b      = b_we_s;
   assign addr_b    = b_addr_s;
   assign wdata_b   = b_wdata_s;

   // Pointer moves just past the cyclically last grant of this cycle
   always_comb begin
      last_idx_s   = b_found_s ? b_idx_s : a_idx_s;
      rr_ptr_nxt_s = rr_ptr_r;
      if (a_found_s) begin
         if (last_idx_s == TAG_W'(NREQ - 32'd1)) begin
            rr_ptr_nxt_s = {TAG_W{1'b0}};
         end else begin
            rr_ptr_nxt_s = last_idx_s + TAG_W'(1);
         end
      end else begin
         rr_ptr_nxt_s = rr_ptr_r;
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_r <= {TAG_W{1'b0}};
      end else begin
         rr_ptr_r <= rr_ptr_nxt_s;
      end
   end

   // In-flight read tags, one stage per cycle of SRAM latency
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pa_vld_r <= {LAT{1'b0}};
         pb_vld_r <= {LAT{1'b0}};
         for (int unsigned k = 0; k < LAT; k++) begin
            pa_id_r[k] <= {TAG_W{1'b0}};
            pb_id_r[k] <= {TAG_W{1'b0}};
         end
      end else begin
         pa_vld_r[0] <= a_found_s & ~a_we_s;
         pb_vld_r[0] <= b_found_s & ~b_we_s;
         pa_id_r[0]  <= a_idx_s;
         pb_id_r[0]  <= b_idx_s;
         for (int unsigned k = 1; k < LAT; k++) begin
            pa_vld_r[k] <= pa_vld_r[k-1];
            pb_vld_r[k] <= pb_vld_r[k-1];
            pa_id_r[k]  <= pa_id_r[k-1];
            pb_id_r[k]  <= pb_id_r[k-1];
         end
      end
   end

   // Steer returning SRAM data; idle slices show their last delivered word
   always_comb begin
      hit_a_s   = {NREQ{1'b0}};
      hit_b_s   = {NREQ{1'b0}};
      rsp_rdata = {(NREQ*DATA_W){1'b0}};
      for (int unsigned i = 0; i < NREQ; i++) begin
         hit_a_s[i] = rst_n && pa_vld_r[LAT-1] && (32'(pa_id_r[LAT-1]) == i);
         hit_b_s[i] = rst_n && pb_vld_r[LAT-1] && (32'(pb_id_r[LAT-1]) == i);
         rsp_rdata[i*DATA_W +: DATA_W] = hit_a_s[i] ? rdata_a : (hit_b_s[i] ? rdata_b : hold_r[i]);
      end
   end

   assign rsp_valid = hit_a_s | hit_b_s;

   // Capture each delivered word so the slice keeps it afterwards
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!rst_n) begin
            hold_r[i] <= {DATA_W{1'b0}};
         end else if (hit_a_s[i]) begin
            hold_r[i] <= rdata_a;
         end else if (hit_b_s[i]) begin
            hold_r[i] <= rdata_b;
         end else begin
            hold_r[i] <= hold_r[i];
         end
      end
   end

endmodule

// File: doc/mp64_sram_dp_arb.md
MP64_SRAM_DP_ARB -- requirements
Module: mp64_sram_dp_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 14, meaning SRAM word-address width.
REQ-003 SHALL have parameter DATA_W, default 64, meaning SRAM word width.
REQ-004 SHALL have parameter OUT_REG, default 0, meaning the attached SRAM's output-register setting; read latency LAT = 1 + OUT_REG.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-007 SHALL have port req_valid, input, NREQ, per-requester request valid.
REQ-008 SHALL have port req_ready, output, NREQ, per-requester grant; the transfer occurs when valid and ready are both 1.
REQ-009 SHALL have port req_we, input, NREQ, per-requester write enable (1 = write, 0 = read).
REQ-010 SHALL have port req_addr, input, NREQ*ADDR_W, packed addresses; requester i is in slice [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have port req_wdata, input, NREQ*DATA_W, packed write data.
REQ-012 SHALL have port rsp_valid, output, NREQ, per-requester read-data valid.
REQ-013 SHALL have port rsp_rdata, output, NREQ*DATA_W, packed per-requester read data.
REQ-014 SHALL have ports ce_a, we_a, addr_a, wdata_a as outputs and rdata_a as input, widths 1/1/ADDR_W/DATA_W/DATA_W, driving SRAM port A.
REQ-015 SHALL have ports ce_b, we_b, addr_b, wdata_b as outputs and rdata_b as input, with the same widths as port A, driving SRAM port B.

Function
REQ-016 SHALL grant at most two requests per cycle: the first is the lowest index at or after rr_ptr (cyclic order) and goes to port A; the next eligible index in cyclic order goes to port B.
REQ-017 SHALL generate req_ready combinationally from the current req_valid, req_we, req_addr and rr_ptr; ready never asserts without valid.
REQ-018 SHALL drive the SRAM port combinationally for each grant: ce=1, we=req_we, addr, wdata. Ungranted ports have ce=0, and addr and wdata are driven to 0.
REQ-019 SHALL block the port B candidate when its address equals the port A address and either request is a write; that requester waits, and the next candidate is considered for port B.
REQ-020 SHALL, after any grant, set rr_ptr to (last granted index + 1) mod NREQ, and hold rr_ptr when nothing is granted.
REQ-021 SHALL treat a write as complete at grant; a write produces no response.
REQ-022 SHALL, for each granted read, pulse rsp_valid[id] for one cycle exactly LAT cycles after the grant, with rsp_rdata slice id equal to that port's rdata.
REQ-023 SHALL track in-flight reads with one LAT-deep pipeline per port holding {valid, id}; back-to-back reads are pipelined at full rate.
REQ-024 SHALL hold rsp_rdata slices for non-responding requesters at their previous value.
REQ-025 SHALL, when two reads for the same requester return in the same cycle, never occur, because one requester is granted at most once per cycle.
REQ-026 SHALL accept that a requester holds valid, we, addr and wdata stable until ready; the block does not check this.

Reset
REQ-027 SHALL, while rst_n=0 at a clock edge, set rr_ptr=0, clear both response pipelines, set rsp_valid=0 and rsp_rdata=0.
REQ-028 SHALL hold req_ready=0 and ce_a=ce_b=0 combinationally while rst_n=0.
REQ-029 SHALL drop reads in flight when reset asserts mid-operation; no rsp_valid for them appears after reset.

Structure
REQ-030 SHALL place LAT computation and the response-tag width function (clog2 of NREQ) in shared package mp64_mem_pkg.
REQ-031 SHALL use one sub-module, mp64_rr_pick, that finds the first set bit at or after a pointer in cyclic order; it is instantiated twice, once for port A and once for port B with A's pick masked.

Verification
REQ-032 Bench SHALL cover: NREQ=4, all valid, all reads, distinct addresses, rr_ptr=0 -> cycle 0 grants 0(A) and 1(B); cycle 1 grants 2 and 3; rsp_valid[0] and [1] assert at cycle LAT.
REQ-033 Bench SHALL cover: req 1 write 0xDEAD at addr 5 and req 2 read addr 5 in the same cycle -> only req 1 granted; req 2 granted next cycle and reads 0xDEAD.
REQ-034 Bench SHALL cover: req 0 and req 3 both reading addr 7 -> both granted in the same cycle, both receive identical data.
REQ-035 Bench SHALL cover: only req 2 valid for 3 cycles with reads of addrs 1, 2, 3 -> ready each cycle; rsp_valid[2] for 3 consecutive cycles with data in order; OUT_REG=0 and OUT_REG=1 both run.
REQ-036 Bench SHALL cover: rst_n low one cycle right after a read grant -> no rsp_valid afterwards, rr_ptr=0, and the next grant goes to the lowest valid index.
